// File: rtl/cpu_defs_pkg.sv
// Shared opcode, ALU code and sequencer state definitions for the control unit.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package cpu_defs_pkg;

  localparam int OPC_BITS = 5;
  localparam int ALU_BITS = 5;

  // Opcode field IR[31:27]
  localparam logic [OPC_BITS-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_BITS-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_BITS-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_BITS-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_BITS-1:0] OP_IN   = 5'b10110;
  localparam logic [OPC_BITS-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPC_BITS-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_BITS-1:0] OP_HALT = 5'b11011;

  // ALU operation codes; 0 means the ALU is idle
  localparam logic [ALU_BITS-1:0] ALU_NONE = 5'b00000;
  localparam logic [ALU_BITS-1:0] ALU_ADD  = 5'b00001;
  localparam logic [ALU_BITS-1:0] ALU_SUB  = 5'b00010;
  localparam logic [ALU_BITS-1:0] ALU_AND  = 5'b00011;
  localparam logic [ALU_BITS-1:0] ALU_OR   = 5'b00100;

  // T0..T7 encode as 0..7 so the step index is the state value itself
  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_RST  = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  function automatic logic is_legal_op(input logic [OPC_BITS-1:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_IN, OP_OUT, OP_NOP, OP_HALT: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_map.sv
// Maps a latched opcode to the ALU operation it needs in its execute step.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module alu_op_map
  import cpu_defs_pkg::*;
(
  input  logic [OPC_BITS-1:0] opcode_i,
  output logic [ALU_BITS-1:0] alu_o
);

  // Address-forming ops (ld/ldi/st) and addi all add an immediate
  always_comb begin
    alu_o = ALU_NONE;
    case (opcode_i)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: alu_o = ALU_ADD;
      OP_SUB:                                alu_o = ALU_SUB;
      OP_AND:                                alu_o = ALU_AND;
      OP_OR:                                 alu_o = ALU_OR;
      default:                               alu_o = ALU_NONE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired step sequencer driving the datapath: fetch T0-T2, then per-opcode execute.
// Latency: one control step per clock; outputs decode the current state within the cycle.
// Backpressure: none; free-running until halt, which is left only via reset.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int OPC_W = OPC_BITS,
  parameter int ALU_W = ALU_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_Data,
  output logic             PC_enable,
  output logic             PC_increment_enable,
  output logic             IR_enable,
  output logic             Y_enable,
  output logic             Z_enable,
  output logic             MAR_enable,
  output logic             MDR_enable,
  output logic             r_enable,
  output logic             con_enable,
  output logic             outport_enable,
  output logic             read,
  output logic             write,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             ba_select,
  output logic             PC_select,
  output logic             Z_LO_select,
  output logic             MDR_select,
  output logic             c_select,
  output logic             r_select,
  output logic             inport_select,
  output logic [ALU_W-1:0] alu_instruction,
  output logic             run,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       step
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q;
  logic [ALU_W-1:0] alu_map;

  // Only the opcode field is decoded here; the rest of IR belongs to the datapath
  logic unused_ir;
  assign unused_ir = ^IR_Data[31-OPC_W:0];

  alu_op_map u_alu_op_map (
    .opcode_i (opc_q),
    .alu_o    (alu_map)
  );

  logic is_mem_imm, is_alu3, is_mem;
  assign is_mem_imm = (opc_q == OP_LD) || (opc_q == OP_LDI) || (opc_q == OP_ST);
  assign is_alu3    = (opc_q == OP_ADD) || (opc_q == OP_SUB) ||
                      (opc_q == OP_AND) || (opc_q == OP_OR);
  assign is_mem     = (opc_q == OP_LD) || (opc_q == OP_ST);

  // Next-step selection; instruction length depends on the latched opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (opc_q == OP_HALT)                                          state_d = ST_HALT;
        else if (is_mem_imm || is_alu3 || (opc_q == OP_ADDI))          state_d = ST_T4;
        else                                                           state_d = ST_T0;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = is_mem ? ST_T6 : ST_T0;
      ST_T6:   state_d = ST_T7;
      ST_T7:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // Step register; the opcode is captured on the same edge the IR loads
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T2) opc_q <= IR_Data[31 -: OPC_W];
    end
  end

  // Moore output decode of (step, opcode); everything defaults low
  always_comb begin
    PC_enable = 1'b0;  PC_increment_enable = 1'b0; IR_enable = 1'b0;
    Y_enable = 1'b0;   Z_enable = 1'b0;   MAR_enable = 1'b0;  MDR_enable = 1'b0;
    r_enable = 1'b0;   con_enable = 1'b0; outport_enable = 1'b0;
    read = 1'b0;       write = 1'b0;
    Gra = 1'b0;        Grb = 1'b0;        Grc = 1'b0;         ba_select = 1'b0;
    PC_select = 1'b0;  Z_LO_select = 1'b0; MDR_select = 1'b0;
    c_select = 1'b0;   r_select = 1'b0;   inport_select = 1'b0;
    alu_instruction = '0;
    instr_done = 1'b0; illegal_op = 1'b0;
    run  = (state_q != ST_RST) && (state_q != ST_HALT);
    step = run ? 4'(state_q) : 4'd0;
    case (state_q)
      ST_T0: begin PC_select = 1'b1; MAR_enable = 1'b1; end
      ST_T1: begin PC_increment_enable = 1'b1; read = 1'b1; MDR_enable = 1'b1; end
      ST_T2: begin MDR_select = 1'b1; IR_enable = 1'b1; end
      ST_T3: begin
        if (is_mem_imm) begin
          Grb = 1'b1; ba_select = 1'b1; Y_enable = 1'b1;
        end else if (is_alu3 || (opc_q == OP_ADDI)) begin
          Grb = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
        end else if (opc_q == OP_IN) begin
          inport_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; instr_done = 1'b1;
        end else if (opc_q == OP_OUT) begin
          Gra = 1'b1; r_select = 1'b1; outport_enable = 1'b1; instr_done = 1'b1;
        end else if (opc_q == OP_NOP) begin
          instr_done = 1'b1;
        end else if (!is_legal_op(opc_q)) begin
          illegal_op = 1'b1; instr_done = 1'b1;
        end
      end
      ST_T4: begin
        Z_enable        = 1'b1;
        alu_instruction = alu_map;
        if (is_alu3) begin Grc = 1'b1; r_select = 1'b1; end
        else         c_select = 1'b1;
      end
      ST_T5: begin
        Z_LO_select = 1'b1;
        if (is_mem) MAR_enable = 1'b1;
        else begin Gra = 1'b1; r_enable = 1'b1; instr_done = 1'b1; end
      end
      ST_T6: begin
        MDR_enable = 1'b1;
        if (opc_q == OP_LD) read = 1'b1;
        else begin Gra = 1'b1; r_select = 1'b1; end
      end
      ST_T7: begin
        instr_done = 1'b1;
        if (opc_q == OP_LD) begin MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
        else write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR_Data = 32'h0;

  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable;
  logic MDR_enable, r_enable, con_enable, outport_enable, read, write;
  logic Gra, Grb, Grc, ba_select, PC_select, Z_LO_select, MDR_select;
  logic c_select, r_select, inport_select, run, instr_done, illegal_op;
  logic [4:0] alu_instruction;
  logic [3:0] step;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR_Data(IR_Data),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .con_enable(con_enable), .outport_enable(outport_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .ba_select(ba_select), .PC_select(PC_select), .Z_LO_select(Z_LO_select),
    .MDR_select(MDR_select), .c_select(c_select), .r_select(r_select),
    .inport_select(inport_select), .alu_instruction(alu_instruction),
    .run(run), .instr_done(instr_done), .illegal_op(illegal_op), .step(step)
  );

  always #5 clk = ~clk;

  // One flag bit per 1-bit output
  localparam logic [24:0] F_PCEN   = 25'h1 << 0;
  localparam logic [24:0] F_PCINC  = 25'h1 << 1;
  localparam logic [24:0] F_IREN   = 25'h1 << 2;
  localparam logic [24:0] F_YEN    = 25'h1 << 3;
  localparam logic [24:0] F_ZEN    = 25'h1 << 4;
  localparam logic [24:0] F_MAREN  = 25'h1 << 5;
  localparam logic [24:0] F_MDREN  = 25'h1 << 6;
  localparam logic [24:0] F_REN    = 25'h1 << 7;
  localparam logic [24:0] F_CONEN  = 25'h1 << 8;
  localparam logic [24:0] F_OUTEN  = 25'h1 << 9;
  localparam logic [24:0] F_READ   = 25'h1 << 10;
  localparam logic [24:0] F_WRITE  = 25'h1 << 11;
  localparam logic [24:0] F_GRA    = 25'h1 << 12;
  localparam logic [24:0] F_GRB    = 25'h1 << 13;
  localparam logic [24:0] F_GRC    = 25'h1 << 14;
  localparam logic [24:0] F_BA     = 25'h1 << 15;
  localparam logic [24:0] F_PCSEL  = 25'h1 << 16;
  localparam logic [24:0] F_ZLO    = 25'h1 << 17;
  localparam logic [24:0] F_MDRSEL = 25'h1 << 18;
  localparam logic [24:0] F_CSEL   = 25'h1 << 19;
  localparam logic [24:0] F_RSEL   = 25'h1 << 20;
  localparam logic [24:0] F_INSEL  = 25'h1 << 21;
  localparam logic [24:0] F_RUN    = 25'h1 << 22;
  localparam logic [24:0] F_DONE   = 25'h1 << 23;
  localparam logic [24:0] F_ILL    = 25'h1 << 24;

  logic [33:0] obs;
  assign obs = {illegal_op, instr_done, run, inport_select, r_select, c_select,
                MDR_select, Z_LO_select, PC_select, ba_select, Grc, Grb, Gra,
                write, read, outport_enable, con_enable, r_enable, MDR_enable,
                MAR_enable, Z_enable, Y_enable, IR_enable, PC_increment_enable,
                PC_enable, alu_instruction, step};

  typedef struct {
    string       tag;
    logic [33:0] w;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [24:0] f,
                      input logic [4:0] a, input logic [3:0] s);
    exp_t e;
    e.tag = tag;
    e.w   = {f, a, s};
    sb.push_back(e);
  endtask

  task automatic push_fetch(input string nm);
    push({nm, "_T0"}, F_RUN | F_PCSEL | F_MAREN, 5'd0, 4'd0);
    push({nm, "_T1"}, F_RUN | F_PCINC | F_READ | F_MDREN, 5'd0, 4'd1);
    push({nm, "_T2"}, F_RUN | F_MDRSEL | F_IREN, 5'd0, 4'd2);
  endtask

  task automatic push_addr(input string nm);
    push({nm, "_T3"}, F_RUN | F_GRB | F_BA | F_YEN, 5'd0, 4'd3);
    push({nm, "_T4"}, F_RUN | F_CSEL | F_ZEN, 5'd1, 4'd4);
  endtask

  // Each pushed expectation is checked against one cycle of DUT output
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      assert (obs === e.w) else begin
        n_bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.w);
      end
    end
  endtask

  task automatic do_alu3(input string nm, input logic [31:0] ir, input logic [4:0] code);
    IR_Data = ir;
    push_fetch(nm);
    push({nm, "_T3"}, F_RUN | F_GRB | F_RSEL | F_YEN, 5'd0, 4'd3);
    push({nm, "_T4"}, F_RUN | F_GRC | F_RSEL | F_ZEN, code, 4'd4);
    push({nm, "_T5"}, F_RUN | F_ZLO | F_GRA | F_REN | F_DONE, 5'd0, 4'd5);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for three edges
    for (int i = 0; i < 3; i++) push("reset", 25'h0, 5'd0, 4'd0);
    drain();
    reset = 1'b0;

    // ldi R1,0x65
    IR_Data = 32'h08800065;
    push_fetch("ldi");
    push_addr("ldi");
    push("ldi_T5", F_RUN | F_ZLO | F_GRA | F_REN | F_DONE, 5'd0, 4'd5);
    drain();

    // out R1
    IR_Data = 32'hB8800000;
    push_fetch("out");
    push("out_T3", F_RUN | F_GRA | F_RSEL | F_OUTEN | F_DONE, 5'd0, 4'd3);
    drain();

    // st
    IR_Data = 32'h10800010;
    push_fetch("st");
    push_addr("st");
    push("st_T5", F_RUN | F_ZLO | F_MAREN, 5'd0, 4'd5);
    push("st_T6", F_RUN | F_GRA | F_RSEL | F_MDREN, 5'd0, 4'd6);
    push("st_T7", F_RUN | F_WRITE | F_DONE, 5'd0, 4'd7);
    drain();

    // full ld
    IR_Data = 32'h00800010;
    push_fetch("ld");
    push_addr("ld");
    push("ld_T5", F_RUN | F_ZLO | F_MAREN, 5'd0, 4'd5);
    push("ld_T6", F_RUN | F_READ | F_MDREN, 5'd0, 4'd6);
    push("ld_T7", F_RUN | F_MDRSEL | F_GRA | F_REN | F_DONE, 5'd0, 4'd7);
    drain();

    // register-register ALU ops
    do_alu3("add", 32'h18000000, 5'd1);
    do_alu3("sub", 32'h20000000, 5'd2);
    do_alu3("and", 32'h28000000, 5'd3);
    do_alu3("or",  32'h30000000, 5'd4);

    // addi
    IR_Data = 32'h60000000;
    push_fetch("addi");
    push("addi_T3", F_RUN | F_GRB | F_RSEL | F_YEN, 5'd0, 4'd3);
    push("addi_T4", F_RUN | F_CSEL | F_ZEN, 5'd1, 4'd4);
    push("addi_T5", F_RUN | F_ZLO | F_GRA | F_REN | F_DONE, 5'd0, 4'd5);
    drain();

    // in, nop
    IR_Data = 32'hB0000000;
    push_fetch("in");
    push("in_T3", F_RUN | F_INSEL | F_GRA | F_REN | F_DONE, 5'd0, 4'd3);
    drain();
    IR_Data = 32'hD0000000;
    push_fetch("nop");
    push("nop_T3", F_RUN | F_DONE, 5'd0, 4'd3);
    drain();

    // illegal opcode 11111 executes as nop, then fetches again
    IR_Data = 32'hF8000000;
    push_fetch("ill");
    push("ill_T3", F_RUN | F_DONE | F_ILL, 5'd0, 4'd3);
    drain();

    // ld interrupted by reset in T5
    IR_Data = 32'h00800010;
    push_fetch("ldr");
    push_addr("ldr");
    push("ldr_T5", F_RUN | F_ZLO | F_MAREN, 5'd0, 4'd5);
    drain();
    reset = 1'b1;
    push("ldr_rst", 25'h0, 5'd0, 4'd0);
    drain();
    reset = 1'b0;

    // halt: stays frozen until reset
    IR_Data = 32'hD8000000;
    push_fetch("halt");
    push("halt_T3", F_RUN, 5'd0, 4'd3);
    for (int i = 0; i < 20; i++) push("halted", 25'h0, 5'd0, 4'd0);
    drain();
    reset = 1'b1;
    push("halt_rst", 25'h0, 5'd0, 4'd0);
    drain();
    reset = 1'b0;
    IR_Data = 32'hD0000000;
    push_fetch("post");
    push("post_T3", F_RUN | F_DONE, 5'd0, 4'd3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
